// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract sequencer built around a single 4-bit carry-select slice.
// Walks the operands LS nibble first, registering the inter-slice carry, and holds the result until accepted.

module nibble_csa_slice (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] sum0;
    logic [4:0] sum1;

    // Both carry hypotheses are computed in parallel; the late-arriving carry only drives the mux.
    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + 5'd1;
    assign {cout, sum} = cin ? sum1 : sum0;

endmodule

module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned LAST   = NSLICE - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [3:0]        slice_a;
    logic [3:0]        slice_b;
    logic [3:0]        slice_sum;
    logic              slice_cout;
    logic [IDXW+1:0]   nib_base;

    // Nibble select for the current slice position.
    assign nib_base = {idx_q, 2'b00};
    assign slice_a  = a_q[nib_base +: 4];
    assign slice_b  = b_q[nib_base +: 4];

    nibble_csa_slice u_slice (
        .cin  (carry_q),
        .a    (slice_a),
        .b    (slice_b),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                result_d[nib_base +: 4] = slice_sum;
                carry_d                 = slice_cout;
                if (idx_q == IDXW'(LAST)) begin
                    cout_d  = slice_cout;
                    // Signed overflow: like-signed operands producing an opposite-signed sum.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake flags are pure state decodes; no input reaches them combinationally.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed signed/unsigned cases, backpressure,
// mid-operation reset and a random back-to-back stream against an arithmetic reference model.

module tb_nibble_serial_adder_ctrl;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             sub = 1'b0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk16(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %04h want %04h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: plain unsigned/signed integer maths.
    function automatic void ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s, input logic c,
                                   output logic [WIDTH-1:0] r, output logic co, output logic ov);
        int ua, ub, u, sa, sb, sv;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            u  = ua - ub;
            co = (ua >= ub);
            sv = sa - sb;
        end else begin
            u  = ua + ub + int'(c);
            co = (u >= (1 << WIDTH));
            sv = sa + sb + int'(c);
        end
        r  = WIDTH'(u);
        ov = (sv > 32767) || (sv < -32768);
    endfunction

    // Transaction-level model: idle / counting down NSLICE edges / holding a result.
    typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
    mph_t             m_ph   = M_IDLE;
    int               m_cnt  = 0;
    logic [WIDTH-1:0] m_res  = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf  = 1'b0;
    logic             m_zero = 1'b1;
    int               acc_q[$];

    always @(posedge clk or posedge rst) begin
        logic [WIDTH-1:0] r;
        logic co, ov;
        if (rst) begin
            m_ph   <= M_IDLE;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_zero <= 1'b1;
        end else begin
            case (m_ph)
                M_IDLE: if (in_valid) begin
                    ref_op(op_a, op_b, sub, cin, r, co, ov);
                    m_res  <= r;
                    m_cout <= co;
                    m_ovf  <= ov;
                    m_zero <= 1'b0;
                    m_cnt  <= NSLICE;
                    m_ph   <= M_RUN;
                    acc_q.push_back(cyc);
                end
                M_RUN: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) m_ph <= M_DONE;
                end
                M_DONE: if (out_ready) m_ph <= M_IDLE;
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk1("in_ready", in_ready, m_ph == M_IDLE);
        chk1("out_valid", out_valid, m_ph == M_DONE);
        chk1("busy", busy, m_ph != M_IDLE);
        if (m_ph == M_DONE || m_zero) begin
            chk16("result", result, m_res);
            chk1("cout", cout, m_cout);
            chk1("overflow", overflow, m_ovf);
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic c,
                          input logic [WIDTH-1:0] er, input logic eco, input logic eov,
                          input int hold);
        int k;
        bit seen;
        @(negedge clk);
        op_a = a; op_b = b; sub = s; cin = c;
        in_valid = 1'b1;
        out_ready = 1'b0;
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                in_valid = 1'b0;
                op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
            end
            if (out_valid) seen = 1;
        end
        total++;
        if (!seen || k != int'(NSLICE) + 1) begin
            bad++;
            $display("FAIL latency: got %0d negedges (seen=%0b) want %0d", k, seen, NSLICE + 1);
        end
        if (seen) begin
            chk16("lit_result", result, er);
            chk1("lit_cout", cout, eco);
            chk1("lit_overflow", overflow, eov);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            chk16("hold_result", result, er);
            chk1("hold_valid", out_valid, 1'b1);
            chk1("hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk1("ack_in_ready", in_ready, 1'b1);
        chk1("ack_out_valid", out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk16("rst_result", result, '0);
        chk1("rst_cout", cout, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    endtask

    task automatic stream(input int nops);
        int n, guard, first;
        n = 0;
        guard = 0;
        first = acc_q.size();
        out_ready = 1'b1;
        while (guard < 400) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                if (n == nops) break;
                op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
                in_valid = 1'b1;
                n++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (acc_q.size() - first != nops) begin
            bad++;
            $display("FAIL stream_count: got %0d accepts want %0d", acc_q.size() - first, nops);
        end
        for (int i = first + 1; i < acc_q.size(); i++) begin
            total++;
            if (acc_q[i] - acc_q[i-1] != int'(NSLICE) + 2) begin
                bad++;
                $display("FAIL stream_ii: got %0d want %0d", acc_q[i] - acc_q[i-1], NSLICE + 2);
            end
        end
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h000F, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 10);
        run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        mid_reset();
        stream(20);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single internal 4-bit carry-select adder slice (carry-in, 4-bit a, 4-bit b -> 4-bit sum, carry-out). It accepts one operation per valid/ready handshake and walks the operands least-significant nibble first, registering the inter-slice carry. It produces the full result, carry-out and signed overflow, and holds them until the consumer accepts. It sits between the ALU issue logic and the writeback path wherever a full-width adder is too costly.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; NSLICE = WIDTH/4.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request presents an operation.
- in_ready  out  1  block can accept; high only in IDLE.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- sub  in  1  0: A+B+cin; 1: A−B (A + ~B + 1, cin ignored).
- cin  in  1  carry-in for add.
- out_valid  out  1  result registers valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry-out of MSB slice (for sub: 1 = no borrow).
- overflow  out  1  signed two's-complement overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Slice index idx is a register of width ceil(log2(NSLICE)), minimum 1 bit.
- IDLE: in_ready=1. On in_valid&&in_ready, latch A=op_a, B'=sub ? ~op_b : op_b, carry=sub ? 1 : cin, idx=0, and go to RUN. in_valid low: stay.
- RUN: the adder slice is driven with A[4·idx+3:4·idx], B'[4·idx+3:4·idx], carry. At each edge, the slice sum is written into result[4·idx+3:4·idx] and carry <= slice carry-out.
  - idx<NSLICE−1: idx++, stay in RUN.
  - idx==NSLICE−1: cout <= slice carry-out, overflow <= (A[WIDTH−1]==B'[WIDTH−1]) && (slice sum bit 3 != A[WIDTH−1]), go to DONE.
- DONE: out_valid=1. result, cout and overflow are held stable. On out_ready, go to IDLE. out_ready low: stay indefinitely.
- in_valid in RUN/DONE is ignored and not latched. Operands may change after the accept edge without effect.
- out_ready outside DONE is ignored.
- result contents during RUN are undefined to the consumer. Only the out_valid cycle is architecturally meaningful.
- Modular arithmetic: result = (A + B' + carry) mod 2^WIDTH. cout = bit WIDTH of that sum.
- Reset (any time, including mid-RUN or DONE): state=IDLE, idx=0, carry=0, result=0, cout=0, overflow=0, out_valid=0, busy=0. in_ready goes to 1 immediately, since it is combinational from state. An operation interrupted by reset is discarded with no output.

## Timing
- Accept edge = the edge where in_valid&&in_ready. RUN occupies the following NSLICE cycles. out_valid rises NSLICE edges after the accept edge (4 for WIDTH=16).
- Consumer accept edge (out_valid&&out_ready): out_valid=0 and in_ready=1 in the next cycle. No accept is possible in the DONE cycle itself.
- Minimum initiation interval is NSLICE+2 cycles (accept, NSLICE RUN, DONE handshake, back in IDLE).
- in_ready, out_valid and busy are decoded purely from state registers, with no combinational path from inputs.
- The critical path is one 4-bit carry-select slice plus the nibble mux. Carry is registered between slices.

## Test plan
- Reset, then add with WIDTH=16, op_a=0x1234, op_b=0x4321, sub=0, cin=0 -> result=0x5555, cout=0, overflow=0. out_valid rises exactly 4 edges after the accept edge.
- Add with op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1, overflow=0, exercising carry across all slices. Add with op_a=0x000F, op_b=0x0000, cin=1 -> result=0x0010, cout=0.
- Signed cases:
  - Add 0x7FFF+0x0001 -> 0x8000, cout=0, overflow=1.
  - Sub 0x8000−0x0001 -> 0x7FFF, cout=1, overflow=1.
  - Sub 0x0005−0x0007 -> 0xFFFE, cout=0, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new operands -> out_valid, result, cout and overflow remain stable, and in_ready stays 0. Assert out_ready -> in_ready=1 on the next cycle, and the next operation returns its correct result.
- Reset mid-operation: assert rst while idx=2 in RUN -> all outputs are 0 immediately, with no out_valid. After rst deasserts, in_ready=1, and the op 0x00FF+0x0001 returns 0x0100.
- Back-to-back stream of 20 random ops (mixed sub/cin), with the consumer always ready, checked against a reference model -> every result, cout and overflow matches, with an initiation interval of exactly 6 cycles.
